// File: rtl/mem_word_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Package     : mem_seq_pkg
// Description : Shared encodings for the memory word sequencer: request size
//               codes, FSM state encoding and timeout-counter sizing helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_seq_pkg;

  // Request size encodings
  localparam logic [1:0] SZ_BYTE    = 2'b00;
  localparam logic [1:0] SZ_HALF    = 2'b01;
  localparam logic [1:0] SZ_WORD    = 2'b10;
  localparam logic [1:0] SZ_ILLEGAL = 2'b11;

  // Sequencer FSM states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_GAP    = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  localparam int DEF_TIMEOUT_CYCLES = 1023;
  localparam int DEF_TMO_CNT_W      = $clog2(DEF_TIMEOUT_CYCLES + 1);

  // Width of a counter that must be able to hold the value n
  function automatic int tmo_cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

  // A request is rejected when its size is illegal or the address is not
  // naturally aligned to that size.
  function automatic logic req_rejected(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_HALF: bad = addr_lo[0];
      SZ_WORD: bad = (addr_lo != 2'b00);
      SZ_ILLEGAL: bad = 1'b1;
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_word_sequencer_load_extend.sv
`default_nettype none
// ============================================================================
// Module      : mem_load_extend
// Description : Combinational little-endian lane assembly with sign or zero
//               extension of byte and half loads to a 32-bit word.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_load_extend
  import mem_seq_pkg::*;
(
  input  logic [3:0][7:0] lanes_i,
  input  logic [1:0]      size_i,
  input  logic            unsigned_i,
  output logic [31:0]     data_o
);

  logic fill_byte;
  logic fill_half;

  assign fill_byte = ~unsigned_i & lanes_i[0][7];
  assign fill_half = ~unsigned_i & lanes_i[1][7];

  // Select the extension according to access size; lane 0 is the lowest address
  always_comb begin
    data_o = '0;
    case (size_i)
      SZ_BYTE: data_o = {{24{fill_byte}}, lanes_i[0]};
      SZ_HALF: data_o = {{16{fill_half}}, lanes_i[1], lanes_i[0]};
      default: data_o = {lanes_i[3], lanes_i[2], lanes_i[1], lanes_i[0]};
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_word_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mem_word_sequencer
// Description : Splits one CPU load/store (byte/half/word) into 1/2/4
//               sequential byte accesses on a byte-wide memory bus, waiting
//               on bus_ready per byte, with a one-cycle gap between bytes and
//               a single response pulse carrying extended load data.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_word_sequencer
  import mem_seq_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDRESS_WIDTH  = 32,
  parameter int WORD_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [1:0]               req_size,
  input  logic                     req_unsigned,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [WORD_WIDTH-1:0]    req_wdata,
  output logic                     resp_valid,
  output logic [WORD_WIDTH-1:0]    resp_rdata,
  output logic                     resp_err,
  output logic                     bus_read,
  output logic                     bus_write,
  output logic [ADDRESS_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0]    bus_wdata,
  input  logic [DATA_WIDTH-1:0]    bus_rdata,
  input  logic                     bus_ready
);

  localparam int CNT_W = tmo_cnt_width(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e                   state_q,     state_d;
  logic                     write_q,     write_d;
  logic [1:0]               size_q,      size_d;
  logic                     unsigned_q,  unsigned_d;
  logic [WORD_WIDTH-1:0]    wdata_q,     wdata_d;
  logic [1:0]               k_q,         k_d;
  logic [1:0]               last_q,      last_d;
  logic [3:0][7:0]          lanes_q,     lanes_d;
  logic                     err_q,       err_d;
  logic [CNT_W-1:0]         cnt_q,       cnt_d;
  logic [ADDRESS_WIDTH-1:0] bus_addr_q,  bus_addr_d;
  logic [DATA_WIDTH-1:0]    bus_wdata_q, bus_wdata_d;

  logic [31:0] ext_data;
  logic        in_access;

  mem_load_extend u_extend (
    .lanes_i    (lanes_q),
    .size_i     (size_q),
    .unsigned_i (unsigned_q),
    .data_o     (ext_data)
  );

  // State and datapath registers; reset returns to idle and drops the strobes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      write_q     <= 1'b0;
      size_q      <= SZ_BYTE;
      unsigned_q  <= 1'b0;
      wdata_q     <= '0;
      k_q         <= 2'd0;
      last_q      <= 2'd0;
      lanes_q     <= '0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      size_q      <= size_d;
      unsigned_q  <= unsigned_d;
      wdata_q     <= wdata_d;
      k_q         <= k_d;
      last_q      <= last_d;
      lanes_q     <= lanes_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
    end
  end

  // Next-state logic: accept, sequence bytes with gaps, time out, respond
  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    size_d      = size_q;
    unsigned_d  = unsigned_q;
    wdata_d     = wdata_q;
    k_d         = k_q;
    last_d      = last_q;
    lanes_d     = lanes_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          write_d    = req_write;
          size_d     = req_size;
          unsigned_d = req_unsigned;
          wdata_d    = req_wdata;
          lanes_d    = '0;
          k_d        = 2'd0;
          cnt_d      = '0;
          case (req_size)
            SZ_HALF: last_d = 2'd1;
            SZ_WORD: last_d = 2'd3;
            default: last_d = 2'd0;
          endcase
          if (req_rejected(req_size, req_addr[1:0])) begin
            // Rejected requests never touch the bus; bus_addr/bus_wdata hold
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else begin
            err_d       = 1'b0;
            bus_addr_d  = req_addr;
            bus_wdata_d = req_wdata[7:0];
            state_d     = ST_ACCESS;
          end
        end
      end

      ST_ACCESS: begin
        if (bus_ready) begin
          if (!write_q) begin
            lanes_d[k_q] = bus_rdata;
          end
          if (k_q == last_q) begin
            state_d = ST_RESP;
          end else begin
            k_d     = k_q + 2'd1;
            state_d = ST_GAP;
          end
        end else if (cnt_q == CNT_LAST) begin
          // Abandon the remaining bytes; earlier stores are not undone
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_GAP: begin
        // Accesses are aligned, so the next byte address never carries out
        cnt_d       = '0;
        bus_addr_d  = bus_addr_q + ADDRESS_WIDTH'(1);
        bus_wdata_d = wdata_q[{k_q, 3'b000} +: 8];
        state_d     = ST_ACCESS;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign in_access  = (state_q == ST_ACCESS);
  assign req_ready  = (state_q == ST_IDLE);
  assign bus_read   = in_access & ~write_q;
  assign bus_write  = in_access &  write_q;
  assign bus_addr   = bus_addr_q;
  assign bus_wdata  = bus_wdata_q;
  assign resp_valid = (state_q == ST_RESP);
  assign resp_err   = resp_valid & err_q;
  assign resp_rdata = (resp_valid && !err_q && !write_q) ? WORD_WIDTH'(ext_data) : '0;

endmodule
`default_nettype wire

// File: tb/tb_mem_word_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_word_sequencer
// Description : Directed self-checking bench for mem_word_sequencer. Inputs
//               change and outputs are sampled on the falling clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_word_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        bus_read;
  logic        bus_write;
  logic [31:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic [7:0]  bus_rdata;
  logic        bus_ready;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  mem_word_sequencer #(
    .DATA_WIDTH     (8),
    .ADDRESS_WIDTH  (32),
    .WORD_WIDTH     (32),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .bus_read     (bus_read),
    .bus_write    (bus_write),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_rdata    (bus_rdata),
    .bus_ready    (bus_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Present a request for one cycle; must be called at a falling edge while idle
  task automatic start(input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd);
    req_write    = wr;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wd;
    req_valid    = 1'b1;
    tick();
    req_valid    = 1'b0;
  endtask

  // Zero-wait word load: byte k in cycle 1+2k, response in cycle 8
  task automatic word_load(input logic [31:0] addr, input logic [31:0] data);
    start(1'b0, 2'b10, 1'b0, addr, 32'h0);
    for (int k = 0; k < 4; k++) begin
      chk("wl_read", {31'b0, bus_read}, 32'd1);
      chk("wl_addr", bus_addr, addr + k);
      bus_rdata = data[8*k +: 8];
      tick();
      if (k < 3) begin
        chk("wl_gap_read", {31'b0, bus_read}, 32'd0);
        chk("wl_gap_addr_hold", bus_addr, addr + k);
        tick();
      end
    end
    chk("wl_resp_valid", {31'b0, resp_valid}, 32'd1);
    chk("wl_resp_rdata", resp_rdata, data);
    chk("wl_resp_err", {31'b0, resp_err}, 32'd0);
    tick();
    chk("wl_back_ready", {31'b0, req_ready}, 32'd1);
    chk("wl_pulse_end", {31'b0, resp_valid}, 32'd0);
  endtask

  initial begin
    rst          = 1'b0;
    req_valid    = 1'b0;
    req_write    = 1'b0;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_addr     = 32'h0;
    req_wdata    = 32'h0;
    bus_rdata    = 8'h00;
    bus_ready    = 1'b1;

    // Reset values
    #2;
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_bus_read", {31'b0, bus_read}, 32'd0);
    chk("rst_bus_write", {31'b0, bus_write}, 32'd0);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_resp_err", {31'b0, resp_err}, 32'd0);
    chk("rst_bus_addr", bus_addr, 32'h0);
    chk("rst_bus_wdata", {24'b0, bus_wdata}, 32'h0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    tick();
    rst = 1'b1;
    tick();

    // Word load, zero-wait bus
    word_load(32'h0010_0004, 32'h4433_2211);

    // Signed byte load, ready rises after 5 wait cycles
    bus_ready = 1'b0;
    start(1'b0, 2'b00, 1'b0, 32'h0000_0003, 32'h0);
    for (int i = 0; i < 6; i++) begin
      chk("sb_read_held", {31'b0, bus_read}, 32'd1);
      chk("sb_addr", bus_addr, 32'h0000_0003);
      if (i == 5) begin
        bus_ready = 1'b1;
        bus_rdata = 8'h80;
      end
      tick();
    end
    chk("sb_read_drop", {31'b0, bus_read}, 32'd0);
    chk("sb_resp_valid", {31'b0, resp_valid}, 32'd1);
    chk("sb_rdata", resp_rdata, 32'hFFFF_FF80);
    chk("sb_err", {31'b0, resp_err}, 32'd0);
    tick();

    // Same byte load, zero-extended
    start(1'b0, 2'b00, 1'b1, 32'h0000_0003, 32'h0);
    chk("ub_read", {31'b0, bus_read}, 32'd1);
    tick();
    chk("ub_resp_valid", {31'b0, resp_valid}, 32'd1);
    chk("ub_rdata", resp_rdata, 32'h0000_0080);
    tick();

    // Half store
    start(1'b1, 2'b01, 1'b0, 32'h0010_0002, 32'hDEAD_BEEF);
    chk("hs_write0", {31'b0, bus_write}, 32'd1);
    chk("hs_read0", {31'b0, bus_read}, 32'd0);
    chk("hs_addr0", bus_addr, 32'h0010_0002);
    chk("hs_wdata0", {24'b0, bus_wdata}, 32'h0000_00EF);
    tick();
    chk("hs_gap", {31'b0, bus_write}, 32'd0);
    chk("hs_gap_wdata_hold", {24'b0, bus_wdata}, 32'h0000_00EF);
    tick();
    chk("hs_write1", {31'b0, bus_write}, 32'd1);
    chk("hs_addr1", bus_addr, 32'h0010_0003);
    chk("hs_wdata1", {24'b0, bus_wdata}, 32'h0000_00BE);
    tick();
    chk("hs_resp_valid", {31'b0, resp_valid}, 32'd1);
    chk("hs_err", {31'b0, resp_err}, 32'd0);
    chk("hs_rdata", resp_rdata, 32'h0);
    tick();

    // Misaligned word load
    start(1'b0, 2'b10, 1'b0, 32'h0010_0001, 32'h0);
    chk("mis_no_read", {31'b0, bus_read}, 32'd0);
    chk("mis_no_write", {31'b0, bus_write}, 32'd0);
    chk("mis_resp_valid", {31'b0, resp_valid}, 32'd1);
    chk("mis_err", {31'b0, resp_err}, 32'd1);
    chk("mis_rdata", resp_rdata, 32'h0);
    chk("mis_addr_hold", bus_addr, 32'h0010_0003);
    tick();
    chk("mis_ready", {31'b0, req_ready}, 32'd1);

    // Illegal size
    start(1'b0, 2'b11, 1'b0, 32'h0, 32'h0);
    chk("ill_no_read", {31'b0, bus_read}, 32'd0);
    chk("ill_resp_valid", {31'b0, resp_valid}, 32'd1);
    chk("ill_err", {31'b0, resp_err}, 32'd1);
    tick();
    chk("ill_ready", {31'b0, req_ready}, 32'd1);

    // Timeout: bus never ready, strobe held 16 cycles
    bus_ready = 1'b0;
    start(1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 16; i++) begin
      chk("to_read_held", {31'b0, bus_read}, 32'd1);
      tick();
    end
    chk("to_read_drop", {31'b0, bus_read}, 32'd0);
    chk("to_resp_valid", {31'b0, resp_valid}, 32'd1);
    chk("to_err", {31'b0, resp_err}, 32'd1);
    chk("to_rdata", resp_rdata, 32'h0);
    tick();
    chk("to_idle", {31'b0, req_ready}, 32'd1);
    bus_ready = 1'b1;

    // Reset asserted during byte 2 of a word load
    start(1'b0, 2'b10, 1'b0, 32'h0010_0008, 32'h0);
    chk("ra_read0", {31'b0, bus_read}, 32'd1);
    tick();
    tick();
    tick();
    tick();
    chk("ra_read2", {31'b0, bus_read}, 32'd1);
    chk("ra_addr2", bus_addr, 32'h0010_000A);
    rst = 1'b0;
    #1;
    chk("ra_read_drop", {31'b0, bus_read}, 32'd0);
    chk("ra_write_low", {31'b0, bus_write}, 32'd0);
    chk("ra_no_resp", {31'b0, resp_valid}, 32'd0);
    chk("ra_ready", {31'b0, req_ready}, 32'd1);
    tick();
    chk("ra_no_resp_hold", {31'b0, resp_valid}, 32'd0);
    rst = 1'b1;
    tick();
    chk("ra_no_resp_after", {31'b0, resp_valid}, 32'd0);
    chk("ra_ready_after", {31'b0, req_ready}, 32'd1);
    word_load(32'h0010_0008, 32'hA4A3_A2A1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  // Hard bound on run time in case the sequence stalls
  initial begin
    #100000;
    $display("FAIL watchdog: observed no completion expected finish before 100000");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
